cov_readout: RTL and testbench

COV_READOUT -- requirements
Module: cov_readout

---
 rtl/cov_readout.sv | 118 +++++++++++
 tb/tb_cov_readout.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cov_readout.sv
// Snapshot-and-stream readout for a 4x4 covariance accumulator matrix.
// Optional macro COV_READOUT_UPPER_EN streams only the upper triangle (r<=c).
module cov_readout #(
  parameter int ENTRY_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [16*ENTRY_W-1:0]   matrix_in,
  output logic                    acc_clear,
  output logic                    busy,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ENTRY_W-1:0]      m_data,
  output logic [3:0]              m_index,
  output logic                    m_last,
  output logic                    overrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [3:0] FIRST_INDEX = 4'd0;
  localparam logic [3:0] LAST_INDEX  = 4'd15;

  state_t             state_reg, state_next;
  logic [ENTRY_W-1:0] snap_reg [16];
  logic [3:0]         index_reg, index_next;
  logic               acc_clear_reg;
  logic               overrun_reg;
  logic               capture;

  // Successor of an entry index within one frame.
  function automatic logic [3:0] step_index(input logic [3:0] idx);
`ifdef COV_READOUT_UPPER_EN
    // Skip the strictly-lower entries: row r restarts at column r.
    case (idx)
      4'd3:    step_index = 4'd5;
      4'd7:    step_index = 4'd10;
      4'd11:   step_index = 4'd15;
      default: step_index = idx + 4'd1;
    endcase
`else
    step_index = idx + 4'd1;
`endif
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      index_reg     <= FIRST_INDEX;
      acc_clear_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      acc_clear_reg <= capture;
      if (state_reg == STREAM && start)
        overrun_reg <= 1'b1;
    end
  end

  // Snapshot bank decouples the stream from the live accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        snap_reg[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < 16; i++)
        snap_reg[i] <= matrix_in[i*ENTRY_W +: ENTRY_W];
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    capture    = 1'b0;
    busy       = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_index    = 4'd0;
    m_last     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          index_next = FIRST_INDEX;
          state_next = STREAM;
        end
      end
      STREAM: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = snap_reg[index_reg];
        m_index = index_reg;
        m_last  = (index_reg == LAST_INDEX);
        if (m_ready) begin
          if (index_reg == LAST_INDEX) begin
            index_next = FIRST_INDEX;
            state_next = IDLE;
          end else begin
            index_next = step_index(index_reg);
          end
        end
      end
      default: begin
        state_next = IDLE;
        index_next = FIRST_INDEX;
      end
    endcase
  end

  assign acc_clear = acc_clear_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_cov_readout.sv
// Directed bench for cov_readout: table-driven frame plus stall, overrun and reset sequences.
// Honors COV_READOUT_UPPER_EN to pick the expected entry order.
module tb_cov_readout;

  localparam int ENTRY_W = 64;
`ifdef COV_READOUT_UPPER_EN
  localparam int NB = 10;
`else
  localparam int NB = 16;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [16*ENTRY_W-1:0] matrix_in;
  logic                  acc_clear;
  logic                  busy;
  logic                  m_valid;
  logic                  m_ready;
  logic [ENTRY_W-1:0]    m_data;
  logic [3:0]            m_index;
  logic                  m_last;
  logic                  overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ord [16];
  int upper_list [10] = '{0, 1, 2, 3, 5, 6, 7, 10, 11, 15};

  typedef struct {
    logic        start;
    logic        ready;
    logic        ones;
    logic        exp_clear;
    logic        exp_busy;
    logic        exp_valid;
    logic        exp_last;
    logic [3:0]  exp_index;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [NB+2];

  cov_readout #(.ENTRY_W(ENTRY_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .matrix_in (matrix_in),
    .acc_clear (acc_clear),
    .busy      (busy),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_matrix(input logic ones);
    for (int k = 0; k < 16; k++)
      matrix_in[k*ENTRY_W +: ENTRY_W] = ones ? {ENTRY_W{1'b1}} : 64'h1000 + 64'(k);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " acc_clear"}, 64'(acc_clear), 64'd0);
    chk({tag, " busy"},      64'(busy),      64'd0);
    chk({tag, " m_valid"},   64'(m_valid),   64'd0);
    chk({tag, " m_index"},   64'(m_index),   64'd0);
    chk({tag, " m_last"},    64'(m_last),    64'd0);
    chk({tag, " m_data"},    m_data,         64'd0);
  endtask

  task automatic chk_beat(input string tag, input int b);
    chk({tag, " m_valid"}, 64'(m_valid), 64'd1);
    chk({tag, " m_index"}, 64'(m_index), 64'(ord[b]));
    chk({tag, " m_data"},  m_data,       64'h1000 + 64'(ord[b]));
    chk({tag, " m_last"},  64'(m_last),  64'(b == NB-1));
  endtask

  // Full frame with m_ready held high; inputs are changed on the falling edge.
  task automatic run_frame(input string tag);
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      start = 1'b0;
      chk_beat($sformatf("%s beat%0d", tag, b), b);
      chk($sformatf("%s acc_clear%0d", tag, b), 64'(acc_clear), 64'(b == 0));
    end
    @(negedge clk);
    chk_idle({tag, " end"});
  endtask

  initial begin
`ifdef COV_READOUT_UPPER_EN
    for (int i = 0; i < 10; i++) ord[i] = upper_list[i];
    for (int i = 10; i < 16; i++) ord[i] = 0;
`else
    for (int i = 0; i < 16; i++) ord[i] = i;
`endif

    // Table: each row's expectations are sampled at a falling edge, then its inputs are applied.
    vecs[0] = '{start: 1'b1, ready: 1'b1, ones: 1'b0, exp_clear: 1'b0, exp_busy: 1'b0,
                exp_valid: 1'b0, exp_last: 1'b0, exp_index: 4'd0, exp_data: 64'd0};
    for (int k = 0; k < NB; k++)
      vecs[k+1] = '{start: 1'b0, ready: 1'b1, ones: 1'b1, exp_clear: (k == 0), exp_busy: 1'b1,
                    exp_valid: 1'b1, exp_last: (k == NB-1), exp_index: 4'(ord[k]),
                    exp_data: 64'h1000 + 64'(ord[k])};
    vecs[NB+1] = '{start: 1'b0, ready: 1'b0, ones: 1'b0, exp_clear: 1'b0, exp_busy: 1'b0,
                   exp_valid: 1'b0, exp_last: 1'b0, exp_index: 4'd0, exp_data: 64'd0};

    reset = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    set_matrix(1'b0);
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset overrun", 64'(overrun), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < NB+2; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d acc_clear", i), 64'(acc_clear), 64'(vecs[i].exp_clear));
      chk($sformatf("vec%0d busy", i),      64'(busy),      64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d m_valid", i),   64'(m_valid),   64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d m_index", i),   64'(m_index),   64'(vecs[i].exp_index));
      chk($sformatf("vec%0d m_last", i),    64'(m_last),    64'(vecs[i].exp_last));
      chk($sformatf("vec%0d m_data", i),    m_data,         vecs[i].exp_data);
      $display("vec%0d: valid=%0d index=%0d data=%0h last=%0d", i, m_valid, m_index, m_data, m_last);
      start = vecs[i].start;
      m_ready = vecs[i].ready;
      set_matrix(vecs[i].ones);
    end
    chk("table overrun", 64'(overrun), 64'd0);

    // Stall: m_ready alternates 0/1 starting low, so every beat is held once.
    begin
      int b;
      int cycles;
      b = 0;
      cycles = 0;
      @(negedge clk);
      start = 1'b1;
      m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 200 && b < NB; cyc++) begin
        chk_beat($sformatf("stall cyc%0d", cyc), b);
        m_ready = (cyc % 2 == 1);
        if (m_ready) b++;
        cycles++;
        @(negedge clk);
      end
      $display("stall frame: %0d beats in %0d cycles", b, cycles);
      chk("stall cycles", 64'(cycles), 64'(2*NB));
      chk_idle("stall end");
    end

    // Overrun: start pulses during beat 5 and on the final handshake are dropped.
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      chk_beat($sformatf("ovr beat%0d", k), k);
      chk($sformatf("ovr flag%0d", k), 64'(overrun), 64'(k > 5));
      start = (k == 5 || k == NB-1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk_idle($sformatf("ovr after%0d", i));
      chk($sformatf("ovr sticky%0d", i), 64'(overrun), 64'd1);
    end
    $display("overrun sequence: overrun=%0d", overrun);

    // Reset mid-frame at beat 7 clears everything without waiting for a clock edge.
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    chk_beat("rst beat7", 7);
    reset = 1'b1;
    #1;
    chk_idle("rst async");
    chk("rst async overrun", 64'(overrun), 64'd0);
    $display("reset mid-frame: valid=%0d index=%0d overrun=%0d", m_valid, m_index, overrun);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_idle($sformatf("rst after%0d", i));
    end
    run_frame("post-reset");
    $display("post-reset frame done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
